// File: rtl/snow64_scalar_line_access_unit.sv
// snow64_scalar_line_access_unit: one-at-a-time scalar load/store engine over 256-bit LAR lines.
// Reads the line, then either extracts and extends the scalar or merges it and writes the line back.
module snow64_scalar_line_access_unit #(
    parameter int LAR_IDX_W  = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_is_write,
    input  logic [LAR_IDX_W-1:0] req_lar_idx,
    input  logic [1:0]           req_data_type,
    input  logic [1:0]           req_int_type_size,
    input  logic [4:0]           req_data_offset,
    input  logic [63:0]          req_scalar,
    output logic                 line_rd_en,
    output logic [LAR_IDX_W-1:0] line_rd_idx,
    input  logic [255:0]         line_rd_data,
    output logic                 line_wr_en,
    output logic [LAR_IDX_W-1:0] line_wr_idx,
    output logic [255:0]         line_wr_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [63:0]          resp_scalar,
    output logic                 resp_was_write,
    output logic                 resp_err
);
    localparam int CNT_W = 3;

    typedef enum logic [2:0] {IDLE, RD_WAIT, EXTRACT, MERGE, RESP} state_t;

    state_t               state_q, state_d;
    logic                 is_write_q, is_write_d;
    logic [LAR_IDX_W-1:0] lar_idx_q, lar_idx_d;
    logic [1:0]           data_type_q, data_type_d;
    logic [1:0]           size_log_q, size_log_d;
    logic [4:0]           offset_q, offset_d;
    logic [63:0]          scalar_q, scalar_d;
    logic [255:0]         line_q, line_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [63:0]          resp_scalar_q, resp_scalar_d;
    logic                 resp_err_q, resp_err_d;

    logic                 reserved;
    logic [7:0]           bit_sh;
    logic [63:0]          elem_mask, raw, extracted;
    logic                 sgn;
    logic [255:0]         merged;

    assign reserved = req_data_type == 2'd3;

    // Element-aligned bit position: clear the offset bits below the element size.
    always_comb begin
        bit_sh    = {req_data_offset & 5'd0, 3'd0};
        bit_sh    = {offset_q & ~((5'd1 << size_log_q) - 5'd1), 3'd0};
        elem_mask = size_log_q == 2'd0 ? 64'hFF :
                    size_log_q == 2'd1 ? 64'hFFFF :
                    size_log_q == 2'd2 ? 64'hFFFF_FFFF : '1;
        raw       = 64'(line_q >> bit_sh) & elem_mask;
        sgn       = size_log_q == 2'd0 ? raw[7] :
                    size_log_q == 2'd1 ? raw[15] :
                    size_log_q == 2'd2 ? raw[31] : raw[63];
        extracted = (data_type_q == 2'd1 && sgn) ? (raw | ~elem_mask) : raw;
        merged    = (line_q & ~({192'd0, elem_mask} << bit_sh)) |
                    ({192'd0, scalar_q & elem_mask} << bit_sh);
    end

    always_comb begin
        state_d       = state_q;
        is_write_d    = is_write_q;
        lar_idx_d     = lar_idx_q;
        data_type_d   = data_type_q;
        size_log_d    = size_log_q;
        offset_d      = offset_q;
        scalar_d      = scalar_q;
        line_d        = line_q;
        cnt_d         = cnt_q;
        resp_scalar_d = resp_scalar_q;
        resp_err_d    = resp_err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                is_write_d    = req_is_write;
                lar_idx_d     = req_lar_idx;
                data_type_d   = req_data_type;
                size_log_d    = req_data_type == 2'd2 ? 2'd1 : req_int_type_size;
                offset_d      = req_data_offset;
                scalar_d      = req_scalar;
                resp_scalar_d = '0;
                resp_err_d    = reserved;
                cnt_d         = CNT_W'(RD_LATENCY);
                state_d       = reserved ? RESP : RD_WAIT;
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_d == '0) begin
                    line_d  = line_rd_data;
                    state_d = is_write_q ? MERGE : EXTRACT;
                end
            end
            EXTRACT: begin
                resp_scalar_d = extracted;
                state_d       = RESP;
            end
            MERGE: state_d = RESP;
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            is_write_q    <= 1'b0;
            lar_idx_q     <= '0;
            data_type_q   <= '0;
            size_log_q    <= '0;
            offset_q      <= '0;
            scalar_q      <= '0;
            line_q        <= '0;
            cnt_q         <= '0;
            resp_scalar_q <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            is_write_q    <= is_write_d;
            lar_idx_q     <= lar_idx_d;
            data_type_q   <= data_type_d;
            size_log_q    <= size_log_d;
            offset_q      <= offset_d;
            scalar_q      <= scalar_d;
            line_q        <= line_d;
            cnt_q         <= cnt_d;
            resp_scalar_q <= resp_scalar_d;
            resp_err_q    <= resp_err_d;
        end
    end

    // The read is issued in the accept cycle itself; reserved types never touch the line.
    assign req_ready      = state_q == IDLE;
    assign line_rd_en     = req_ready && req_valid && !reserved;
    assign line_rd_idx    = line_rd_en ? req_lar_idx : '0;
    assign line_wr_en     = state_q == MERGE;
    assign line_wr_idx    = lar_idx_q;
    assign line_wr_data   = line_wr_en ? merged : '0;
    assign resp_valid     = state_q == RESP;
    assign resp_scalar    = resp_scalar_q;
    assign resp_was_write = is_write_q;
    assign resp_err       = resp_err_q;
endmodule

// File: tb/tb_snow64_scalar_line_access_unit.sv
// tb_snow64_scalar_line_access_unit: directed table, randomized byte-level model, stall and async-reset sequences.
module tb_snow64_scalar_line_access_unit;
    localparam int L = 1;

    typedef struct {
        logic         w;
        logic [1:0]   dt;
        logic [1:0]   sz;
        logic [4:0]   off;
        logic [3:0]   lar;
        logic [63:0]  sc;
        logic [255:0] line;
        logic [63:0]  exp_sc;
        logic [255:0] exp_line;
        logic         exp_err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b0, rst_n4 = 1'b0;
    logic         req_valid = 1'b0, req_valid4 = 1'b0;
    logic         resp_ready = 1'b0, resp_ready4 = 1'b0;
    logic         req_is_write = 1'b0;
    logic [3:0]   req_lar_idx = '0;
    logic [1:0]   req_data_type = '0, req_int_type_size = '0;
    logic [4:0]   req_data_offset = '0;
    logic [63:0]  req_scalar = '0;

    logic         req_ready, line_rd_en, line_wr_en, resp_valid, resp_was_write, resp_err;
    logic [3:0]   line_rd_idx, line_wr_idx;
    logic [255:0] line_rd_data, line_wr_data;
    logic [63:0]  resp_scalar;

    logic         req_ready4, line_rd_en4, line_wr_en4, resp_valid4, resp_was_write4, resp_err4;
    logic [3:0]   line_rd_idx4, line_wr_idx4;
    logic [255:0] line_rd_data4, line_wr_data4;
    logic [63:0]  resp_scalar4;

    snow64_scalar_line_access_unit #(.LAR_IDX_W(4), .RD_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_write(req_is_write), .req_lar_idx(req_lar_idx), .req_data_type(req_data_type),
        .req_int_type_size(req_int_type_size), .req_data_offset(req_data_offset), .req_scalar(req_scalar),
        .line_rd_en(line_rd_en), .line_rd_idx(line_rd_idx), .line_rd_data(line_rd_data),
        .line_wr_en(line_wr_en), .line_wr_idx(line_wr_idx), .line_wr_data(line_wr_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_scalar(resp_scalar),
        .resp_was_write(resp_was_write), .resp_err(resp_err)
    );

    snow64_scalar_line_access_unit #(.LAR_IDX_W(4), .RD_LATENCY(4)) dut4 (
        .clk(clk), .rst_n(rst_n4), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_is_write(req_is_write), .req_lar_idx(req_lar_idx), .req_data_type(req_data_type),
        .req_int_type_size(req_int_type_size), .req_data_offset(req_data_offset), .req_scalar(req_scalar),
        .line_rd_en(line_rd_en4), .line_rd_idx(line_rd_idx4), .line_rd_data(line_rd_data4),
        .line_wr_en(line_wr_en4), .line_wr_idx(line_wr_idx4), .line_wr_data(line_wr_data4),
        .resp_valid(resp_valid4), .resp_ready(resp_ready4), .resp_scalar(resp_scalar4),
        .resp_was_write(resp_was_write4), .resp_err(resp_err4)
    );

    // Line store model: data appears L cycles after the read pulse, garbage otherwise.
    logic [255:0] mem [16];
    logic         pv [L];
    logic [3:0]   pidx [L];
    always @(posedge clk) begin
        pv[0]   <= line_rd_en;
        pidx[0] <= line_rd_idx;
        for (int i = 1; i < L; i++) begin
            pv[i]   <= pv[i-1];
            pidx[i] <= pidx[i-1];
        end
    end
    assign line_rd_data = pv[L-1] ? mem[pidx[L-1]] : {8{32'hA5A5_5A5A}};

    localparam logic [255:0] LINE4 = {248'd0, 8'hF0};
    logic [3:0] p4 = '0;
    int wr4 = 0;
    always @(posedge clk) begin
        p4 <= {p4[2:0], line_rd_en4};
        if (line_wr_en4 === 1'b1) wr4++;
    end
    assign line_rd_data4 = p4[3] ? LINE4 : '0;

    int pass_cnt = 0, total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chkl(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] ref_load(input logic [255:0] line, input logic [1:0] dt, input logic [1:0] sz,
                                             input logic [4:0] off);
        int n = dt == 2'd2 ? 2 : 1 << sz;
        int base = int'(off) / n * n;
        logic [63:0] v = '0;
        if (dt == 2'd3) return '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = line[8*(base+i) +: 8];
        if (dt == 2'd1 && v[8*n-1]) for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [255:0] ref_store(input logic [255:0] line, input logic [1:0] dt, input logic [1:0] sz,
                                               input logic [4:0] off, input logic [63:0] sc);
        int n = dt == 2'd2 ? 2 : 1 << sz;
        int base = int'(off) / n * n;
        logic [255:0] r = line;
        for (int i = 0; i < n; i++) r[8*(base+i) +: 8] = sc[8*i +: 8];
        return r;
    endfunction

    task automatic set_req(input logic w, input logic [1:0] dt, input logic [1:0] sz, input logic [4:0] off,
                           input logic [63:0] sc, input logic [3:0] lar);
        req_is_write = w;
        req_data_type = dt;
        req_int_type_size = sz;
        req_data_offset = off;
        req_scalar = sc;
        req_lar_idx = lar;
    endtask

    // One transaction on the RD_LATENCY=L unit; j counts negedges after the accept edge.
    task automatic run(input logic w, input logic [1:0] dt, input logic [1:0] sz, input logic [4:0] off,
                       input logic [63:0] sc, input logic [3:0] lar, input logic [63:0] exp_sc,
                       input logic [255:0] exp_line, input logic exp_err, input int stall);
        int lat = -1, rds = 0, wrs = 0, wr_at = -1, busy = 0;
        logic [255:0] wr_data = '0;
        logic [65:0] held;
        @(negedge clk);
        set_req(w, dt, sz, off, sc, lar);
        req_valid = 1'b1;
        resp_ready = 1'b0;
        #1;
        chk("accept_ready", 64'(req_ready), 64'd1);
        rds = int'(line_rd_en);
        if (line_rd_en) chk("rd_idx", 64'(line_rd_idx), 64'(lar));
        @(posedge clk);
        #1 req_valid = 1'b0;
        set_req(~w, 2'($urandom), 2'($urandom), 5'($urandom), {$urandom, $urandom}, 4'($urandom));
        for (int j = 0; j < 20 && lat < 0; j++) begin
            @(negedge clk);
            rds += int'(line_rd_en);
            if (line_wr_en) begin
                wrs++;
                wr_at = j;
                wr_data = line_wr_data;
                chk("wr_idx", 64'(line_wr_idx), 64'(lar));
            end
            if (req_ready) busy++;
            if (resp_valid) lat = j;
        end
        chk("latency", 64'(lat), 64'(exp_err ? 0 : L + 1));
        chk("rd_pulses", 64'(rds), 64'(exp_err ? 0 : 1));
        chk("wr_pulses", 64'(wrs), 64'((w && !exp_err) ? 1 : 0));
        chk("busy_ready", 64'(busy), 64'd0);
        if (w && !exp_err) begin
            chk("wr_cycle", 64'(wr_at), 64'(L));
            chkl("wr_line", wr_data, exp_line);
        end
        chk("resp_scalar", resp_scalar, exp_sc);
        chk("resp_flags", 64'({resp_err, resp_was_write}), 64'({exp_err, w}));
        held = {resp_err, resp_was_write, resp_scalar};
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chkl("stall_hold", 256'({resp_valid, req_ready, resp_err, resp_was_write, resp_scalar}),
                 256'({2'b10, held}));
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("idle_after", 64'({req_ready, resp_valid}), 64'd2);
    endtask

    vec_t vecs [9];

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 2'd1, 2'd0, 5'd31, 4'd1, 64'd0, {8'h80, {31{8'h11}}},
                    64'hFFFF_FFFF_FFFF_FF80, 256'd0, 1'b0};
        vecs[1] = '{1'b0, 2'd0, 2'd2, 5'd13, 4'd2, 64'd0, {{128{1'b1}}, 32'hDEAD_BEEF, {96{1'b1}}},
                    64'h0000_0000_DEAD_BEEF, 256'd0, 1'b0};
        vecs[2] = '{1'b1, 2'd0, 2'd1, 5'd6, 4'd3, 64'h1234_5678_9ABC_7777, {256{1'b1}},
                    64'd0, {{192{1'b1}}, 16'h7777, {48{1'b1}}}, 1'b0};
        vecs[3] = '{1'b1, 2'd3, 2'd1, 5'd4, 4'd4, 64'hFFFF_0000_FFFF_0000, {256{1'b1}},
                    64'd0, 256'd0, 1'b1};
        vecs[4] = '{1'b0, 2'd2, 2'd0, 5'd5, 4'd5, 64'd0, {192'd0, 16'h1234, 16'hBEEF, 32'h5555_5555},
                    64'h0000_0000_0000_BEEF, 256'd0, 1'b0};
        vecs[5] = '{1'b0, 2'd1, 2'd3, 5'd9, 4'd6, 64'd0, {128'd0, 64'h8000_0000_0000_0001, {64{1'b1}}},
                    64'h8000_0000_0000_0001, 256'd0, 1'b0};
        vecs[6] = '{1'b0, 2'd1, 2'd1, 5'd1, 4'd7, 64'd0, {{240{1'b1}}, 16'h7FFF},
                    64'h0000_0000_0000_7FFF, 256'd0, 1'b0};
        vecs[7] = '{1'b1, 2'd1, 2'd2, 5'd30, 4'd8, 64'hFFFF_FFFF_CAFE_F00D, 256'd0,
                    64'd0, {32'hCAFE_F00D, 224'd0}, 1'b0};
        vecs[8] = '{1'b0, 2'd3, 2'd0, 5'd0, 4'd9, 64'd0, {256{1'b1}}, 64'd0, 256'd0, 1'b1};
        for (int i = 0; i < 16; i++) mem[i] = {8{$urandom}};

        repeat (2) @(negedge clk);
        chkl("reset_main", 256'({req_ready, line_rd_en, line_rd_idx, line_wr_en, line_wr_idx, resp_valid,
                                 resp_was_write, resp_err, resp_scalar}), 256'({1'b1, 77'd0}));
        chkl("reset_wr_data", line_wr_data, 256'd0);
        rst_n = 1'b1;
        rst_n4 = 1'b1;

        foreach (vecs[i]) begin
            mem[vecs[i].lar] = vecs[i].line;
            run(vecs[i].w, vecs[i].dt, vecs[i].sz, vecs[i].off, vecs[i].sc, vecs[i].lar,
                vecs[i].exp_sc, vecs[i].exp_line, vecs[i].exp_err, 0);
            if (vecs[i].w && !vecs[i].exp_err) mem[vecs[i].lar] = vecs[i].exp_line;
        end

        mem[10] = {64'd0, 64'hFEDC_BA98_7654_3210, 128'd0};
        run(1'b0, 2'd1, 2'd3, 5'd16, 64'd0, 4'd10, 64'hFEDC_BA98_7654_3210, 256'd0, 1'b0, 5);

        for (int t = 0; t < 60; t++) begin
            logic w;
            logic [1:0] dt, sz;
            logic [4:0] off;
            logic [63:0] sc;
            logic [3:0] lar;
            int r = $urandom_range(0, 9);
            w = 1'($urandom);
            dt = r == 9 ? 2'd3 : 2'(r % 3);
            sz = 2'($urandom);
            off = 5'($urandom);
            sc = {$urandom, $urandom};
            lar = 4'($urandom_range(0, 3));
            run(w, dt, sz, off, sc, lar, w ? 64'd0 : ref_load(mem[lar], dt, sz, off),
                ref_store(mem[lar], dt, sz, off, sc), dt == 2'd3, $urandom_range(0, 2));
            if (w && dt != 2'd3) mem[lar] = ref_store(mem[lar], dt, sz, off, sc);
        end

        begin
            int lat = -1;
            @(negedge clk);
            set_req(1'b0, 2'd1, 2'd0, 5'd0, 64'd0, 4'd2);
            req_valid4 = 1'b1;
            @(posedge clk);
            #1 req_valid4 = 1'b0;
            for (int j = 0; j < 20 && lat < 0; j++) begin
                @(negedge clk);
                if (resp_valid4) lat = j;
            end
            chk("l4_latency", 64'(lat), 64'd5);
            chk("l4_scalar", resp_scalar4, 64'hFFFF_FFFF_FFFF_FFF0);
            resp_ready4 = 1'b1;
            @(posedge clk);
            #1 resp_ready4 = 1'b0;
        end

        @(negedge clk);
        set_req(1'b1, 2'd0, 2'd0, 5'd3, 64'h55, 4'd5);
        req_valid4 = 1'b1;
        @(posedge clk);
        #1 req_valid4 = 1'b0;
        repeat (2) @(negedge clk);
        chk("l4_busy", 64'(req_ready4), 64'd0);
        #2 rst_n4 = 1'b0;
        #1;
        chk("l4_rst_ctl", 64'({req_ready4, line_rd_en4, line_rd_idx4, line_wr_en4, line_wr_idx4, resp_valid4,
                               resp_was_write4, resp_err4}), 64'({1'b1, 13'd0}));
        chkl("l4_rst_wr_data", line_wr_data4, 256'd0);
        chk("l4_rst_scalar", resp_scalar4, 64'd0);
        repeat (3) @(negedge clk);
        rst_n4 = 1'b1;
        repeat (8) @(negedge clk);
        chk("l4_no_write", 64'(wr4), 64'd0);
        chk("l4_idle", 64'({req_ready4, resp_valid4}), 64'd2);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
